// File: rtl/estimador_pkg.sv
// Shared definitions for the windowed I/V mean estimator.
package estimador_pkg;

    // Handshake FSM: IDLE accepts a sample, BUSY is the mandatory gap cycle,
    // OUT publishes the completed window.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Number of samples in a window of size 2^log2_n.
    function automatic int unsigned N_OF(input int unsigned log2_n);
        return 32'd1 << log2_n;
    endfunction

endpackage

// File: rtl/acumulador_canal.sv
// One averaging channel: wide accumulator plus the published mean register.
module acumulador_canal #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned LOG2_N = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             add,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // LOG2_N guard bits make overflow impossible for a full window.
    localparam int unsigned AW = WIDTH + LOG2_N;

    logic [AW-1:0] acc;

    // Accumulate accepted samples; clear wins over add.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add) begin
            acc <= acc + AW'(din);
        end
    end

    // Publish the truncated mean; load sees the sum before the same-edge clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
        end else if (load) begin
            dout <= acc[AW-1:LOG2_N];
        end
    end

endmodule

// File: rtl/estimador_promedio.sv
// Block-average estimator for handshaked current/voltage samples.
module estimador_promedio
    import estimador_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned LOG2_N = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_e,
    input  logic [WIDTH-1:0] I,
    input  logic [WIDTH-1:0] V,
    input  logic             clear,
    output logic             ack_e,
    output logic             valid_e,
    output logic [WIDTH-1:0] result_i,
    output logic [WIDTH-1:0] result_v
);

    localparam int unsigned N     = N_OF(LOG2_N);
    // Keep the counter at least one bit wide so LOG2_N=0 still elaborates.
    localparam int unsigned CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             add, clr_acc, load;

    // State, sample counter and valid pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Next state and channel controls; clear overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        add     = 1'b0;
        clr_acc = 1'b0;
        load    = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            clr_acc = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_e) begin
                        add = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_OUT;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    state_d = ST_IDLE;
                end
                ST_OUT: begin
                    load    = 1'b1;
                    clr_acc = 1'b1;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign ack_e   = (state_q == ST_IDLE);
    assign valid_e = valid_q;

    acumulador_canal #(
        .WIDTH  (WIDTH),
        .LOG2_N (LOG2_N)
    ) u_canal_i (
        .clk   (clk),
        .reset (reset),
        .add   (add),
        .clr   (clr_acc),
        .load  (load),
        .din   (I),
        .dout  (result_i)
    );

    acumulador_canal #(
        .WIDTH  (WIDTH),
        .LOG2_N (LOG2_N)
    ) u_canal_v (
        .clk   (clk),
        .reset (reset),
        .add   (add),
        .clr   (clr_acc),
        .load  (load),
        .din   (V),
        .dout  (result_v)
    );

endmodule

// File: tb/tb_estimador_promedio.sv
// Randomised scoreboard bench for estimador_promedio (LOG2_N=3 and LOG2_N=0 builds).
module tb_estimador_promedio;

    localparam int unsigned L = 3;
    localparam int unsigned N = 1 << L;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_e = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] I = '0;
    logic [31:0] V = '0;
    logic        ack_e, valid_e;
    logic [31:0] result_i, result_v;

    logic        s0_start = 1'b0;
    logic [31:0] s0_i = '0;
    logic [31:0] s0_v = '0;
    logic        ack0, valid0;
    logic [31:0] res0_i, res0_v;

    int asserts = 0;
    int fails   = 0;

    typedef struct {
        logic [31:0] ri;
        logic [31:0] rv;
    } exp_t;
    exp_t exp_q[$];

    // Behavioural model: a window is a list of accepted samples; a sample can
    // only be accepted when the block is ready, and each accept costs a gap cycle.
    bit              m_ready = 1'b1;
    bit              m_out = 1'b0;
    bit              m_valid_now = 1'b0;
    longint unsigned m_sum_i = 0;
    longint unsigned m_sum_v = 0;
    int              m_cnt = 0;
    logic [31:0]     m_res_i = '0;
    logic [31:0]     m_res_v = '0;

    estimador_promedio #(
        .WIDTH  (32),
        .LOG2_N (L)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start_e  (start_e),
        .I        (I),
        .V        (V),
        .clear    (clear),
        .ack_e    (ack_e),
        .valid_e  (valid_e),
        .result_i (result_i),
        .result_v (result_v)
    );

    estimador_promedio #(
        .WIDTH  (32),
        .LOG2_N (0)
    ) dut0 (
        .clk      (clk),
        .reset    (reset),
        .start_e  (s0_start),
        .I        (s0_i),
        .V        (s0_v),
        .clear    (1'b0),
        .ack_e    (ack0),
        .valid_e  (valid0),
        .result_i (res0_i),
        .result_v (res0_v)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b1; m_out = 1'b0; m_valid_now = 1'b0;
        m_sum_i = 0; m_sum_v = 0; m_cnt = 0;
        m_res_i = '0; m_res_v = '0;
        exp_q.delete();
    endtask

    // What the next rising edge does to the model.
    task automatic model_edge(input bit st, input bit clr, input logic [31:0] i,
                              input logic [31:0] v);
        m_valid_now = 1'b0;
        if (clr) begin
            m_sum_i = 0; m_sum_v = 0; m_cnt = 0;
            m_out = 1'b0; m_ready = 1'b1;
        end else if (m_out) begin
            m_res_i = 32'(m_sum_i / N);
            m_res_v = 32'(m_sum_v / N);
            exp_q.push_back('{ri: m_res_i, rv: m_res_v});
            m_valid_now = 1'b1;
            m_sum_i = 0; m_sum_v = 0; m_cnt = 0;
            m_out = 1'b0; m_ready = 1'b1;
        end else if (m_ready) begin
            if (st) begin
                m_sum_i += longint'(i);
                m_sum_v += longint'(v);
                m_cnt++;
                m_ready = 1'b0;
                if (m_cnt == N) m_out = 1'b1;
            end
        end else begin
            m_ready = 1'b1;
        end
    endtask

    // Called at a falling edge: check present outputs, drive, advance one cycle.
    task automatic cycle(input bit st, input bit clr, input logic [31:0] i,
                         input logic [31:0] v);
        check("ack_e", 64'(ack_e), 64'(m_ready));
        check("valid_e", 64'(valid_e), 64'(m_valid_now));
        check("result_i_hold", 64'(result_i), 64'(m_res_i));
        check("result_v_hold", 64'(result_v), 64'(m_res_v));
        start_e = st; clear = clr; I = i; V = v;
        model_edge(st, clr, i, v);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] v);
        while (!m_ready) cycle(1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, i, v);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, '0);
    endtask

    // Monitor: every valid_e pulse must match the oldest expected window.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (valid_e === 1'b1) begin
                asserts++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid: got valid_e=1 expected no pending window");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (result_i !== e.ri || result_v !== e.rv) begin
                        fails++;
                        $display("FAIL window_result: got %0h/%0h expected %0h/%0h",
                                 result_i, result_v, e.ri, e.rv);
                    end
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        check("reset_ack", 64'(ack_e), 64'd1);
        check("reset_valid", 64'(valid_e), 64'd0);
        check("reset_ri", 64'(result_i), 64'd0);
        check("reset_rv", 64'(result_v), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Ramp window on I, constant V.
        for (int k = 1; k <= 8; k++) send(32'(k), 32'd100);
        idle(3);
        check("mean_ramp_i", 64'(result_i), 64'd4);
        check("mean_ramp_v", 64'(result_v), 64'd100);

        // All-ones window must not wrap.
        for (int k = 0; k < 8; k++) send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(3);
        check("sat_i", 64'(result_i), 64'hFFFF_FFFF);
        check("sat_v", 64'(result_v), 64'hFFFF_FFFF);

        // start_e held high: only every other cycle is accepted.
        for (int c = 0; c < 20; c++) cycle(1'b1, 1'b0, 32'(2 * c), 32'(2 * c + 1));
        idle(20);

        // Clear mid-window, then a clean window of 10s.
        for (int k = 0; k < 5; k++) send(32'd50, 32'd50);
        cycle(1'b0, 1'b1, '0, '0);
        for (int k = 0; k < 8; k++) send(32'd10, 32'd20);
        idle(3);
        check("after_clear_i", 64'(result_i), 64'd10);
        check("after_clear_v", 64'(result_v), 64'd20);

        // Clear exactly in the OUT cycle aborts the update.
        for (int k = 0; k < 8; k++) send(32'd77, 32'd77);
        check("model_in_out", 64'(m_out), 64'd1);
        cycle(1'b0, 1'b1, '0, '0);
        idle(3);
        check("clear_out_i", 64'(result_i), 64'd10);
        check("clear_out_v", 64'(result_v), 64'd20);

        // Asynchronous reset mid-window, right after a result is published.
        for (int k = 0; k < 8; k++) send(32'd1000, 32'd3000);
        cycle(1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 3; k++) send(32'd5, 32'd5);
        start_e = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_ack", 64'(ack_e), 64'd1);
        check("async_valid", 64'(valid_e), 64'd0);
        check("async_ri", 64'(result_i), 64'd0);
        check("async_rv", 64'(result_v), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Random traffic with occasional clears.
        for (int c = 0; c < 600; c++) begin
            cycle(($urandom % 4) != 0, ($urandom % 50) == 0, $urandom, $urandom);
        end
        idle(4);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Pass-through build: result equals the sample, one cycle after accept.
        check("n1_ack_idle", 64'(ack0), 64'd1);
        s0_start = 1'b1; s0_i = 32'd7; s0_v = 32'd9;
        @(negedge clk);
        s0_start = 1'b0;
        check("n1_ack_out", 64'(ack0), 64'd0);
        check("n1_valid_early", 64'(valid0), 64'd0);
        @(negedge clk);
        check("n1_valid", 64'(valid0), 64'd1);
        check("n1_ri", 64'(res0_i), 64'd7);
        check("n1_rv", 64'(res0_v), 64'd9);
        check("n1_ack_back", 64'(ack0), 64'd1);
        s0_start = 1'b1; s0_i = 32'hDEAD_BEEF; s0_v = 32'd123;
        @(negedge clk);
        s0_start = 1'b0;
        @(negedge clk);
        check("n1_valid2", 64'(valid0), 64'd1);
        check("n1_ri2", 64'(res0_i), 64'hDEAD_BEEF);
        check("n1_rv2", 64'(res0_v), 64'd123);
        @(negedge clk);
        check("n1_valid_drop", 64'(valid0), 64'd0);
        check("n1_hold", 64'(res0_i), 64'hDEAD_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
